ib_load_scheduler: RTL and testbench

IB_LOAD_SCHEDULER -- requirements
Module: ib_load_scheduler

---
 rtl/ib_load_scheduler.sv | 134 +++++++++++++
 tb/tb_ib_load_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ib_load_scheduler.sv
// ib_load_scheduler: fetches QUEUE_NUM memory rows per tile into a tile buffer and sequences the
// input-buffer push / arm / drain handshake for i_tile_num tiles.
// Optional feature: define IB_SCHED_PERF_EN to enable the busy/stall performance counters.
module ib_load_scheduler #(
    parameter int QUEUE_NUM = 3,
    parameter int QUEUE_LEN = 9,
    parameter int IN_WIDTH  = 8,
    parameter int ADDR_W    = 16,
    parameter int TILE_W    = 8
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_start,
    input  logic [ADDR_W-1:0]                     i_base_addr,
    input  logic [ADDR_W-1:0]                     i_row_stride,
    input  logic [TILE_W-1:0]                     i_tile_num,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic                                  o_mem_req,
    output logic [ADDR_W-1:0]                     o_mem_addr,
    input  logic                                  i_mem_gnt,
    input  logic                                  i_mem_rvalid,
    input  logic [IN_WIDTH*QUEUE_LEN-1:0]         i_mem_rdata,
    output logic                                  o_ib_valid,
    input  logic                                  i_ib_ready,
    output logic [IN_WIDTH*QUEUE_NUM*QUEUE_LEN-1:0] o_ib_data,
    input  logic                                  i_ib_in_done,
    output logic                                  o_ib_ctrl_data_out,
    output logic                                  o_ib_out_active,
    output logic [31:0]                           o_perf_cycles,
    output logic [31:0]                           o_perf_stall
);
    localparam int ROW_W = IN_WIDTH * QUEUE_LEN;
    localparam int RW    = QUEUE_NUM > 1 ? $clog2(QUEUE_NUM) : 1;
    localparam int DW    = $clog2(QUEUE_LEN + QUEUE_NUM);
    localparam logic [RW-1:0] LAST_ROW   = RW'(QUEUE_NUM - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(QUEUE_LEN + QUEUE_NUM - 2);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] PUSH  = 3'd2;
    localparam logic [2:0] ARM   = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]                           state;
    logic [ADDR_W-1:0]                    addr;
    logic [ADDR_W-1:0]                    stride;
    logic [TILE_W-1:0]                    tile_num;
    logic [TILE_W-1:0]                    tile_idx;
    logic [TILE_W-1:0]                    tile_next;
    logic [RW-1:0]                        row;
    logic [DW-1:0]                        drain_cnt;
    logic                                 pending;
    logic [QUEUE_NUM-1:0][ROW_W-1:0]      tile;

    assign tile_next          = tile_idx + TILE_W'(1);
    assign o_busy             = state != IDLE;
    assign o_done             = state == DONE;
    assign o_mem_req          = state == FETCH && !pending;
    assign o_mem_addr         = addr;
    assign o_ib_valid         = state == PUSH;
    assign o_ib_data          = tile;
    assign o_ib_ctrl_data_out = state == ARM && i_ib_in_done;
    assign o_ib_out_active    = state == DRAIN;

    // job sequencing: row fetch with one outstanding read, tile push, arm and fixed-length drain
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            addr      <= '0;
            stride    <= '0;
            tile_num  <= '0;
            tile_idx  <= '0;
            row       <= '0;
            drain_cnt <= '0;
            pending   <= 1'b0;
            tile      <= '0;
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    addr     <= i_base_addr;
                    stride   <= i_row_stride;
                    tile_num <= i_tile_num;
                    tile_idx <= '0;
                    row      <= '0;
                    state    <= i_tile_num == '0 ? DONE : FETCH;
                end
                FETCH: begin
                    if (o_mem_req && i_mem_gnt) pending <= 1'b1;
                    if (pending && i_mem_rvalid) begin
                        pending   <= 1'b0;
                        tile[row] <= i_mem_rdata;
                        addr      <= addr + stride;
                        row       <= row == LAST_ROW ? '0 : row + RW'(1);
                        state     <= row == LAST_ROW ? PUSH : FETCH;
                    end
                end
                PUSH: state <= i_ib_ready ? ARM : PUSH;
                ARM: if (i_ib_in_done) begin
                    state     <= DRAIN;
                    drain_cnt <= '0;
                end
                DRAIN: if (drain_cnt == LAST_DRAIN) begin
                    tile_idx <= tile_next;
                    state    <= tile_next == tile_num ? DONE : FETCH;
                end else begin
                    drain_cnt <= drain_cnt + DW'(1);
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IB_SCHED_PERF_EN
    logic [31:0] perf_cycles;
    logic [31:0] perf_stall;
    // saturating busy and grant-stall counters, cleared when a job is accepted
    always_ff @(posedge i_clk) begin
        if (i_rst || (state == IDLE && i_start)) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (o_busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
            if (o_mem_req && !i_mem_gnt && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
        end
    end
    assign o_perf_cycles = perf_cycles;
    assign o_perf_stall  = perf_stall;
`else
    assign o_perf_cycles = '0;
    assign o_perf_stall  = '0;
`endif
endmodule

// File: tb/tb_ib_load_scheduler.sv
// tb_ib_load_scheduler: randomized memory/buffer responder with a behavioural job model for ib_load_scheduler.
module tb_ib_load_scheduler;
    localparam int QN = 3, QL = 9, IW = 8, AW = 16, TW = 8;
    localparam int ROW_W = IW * QL;
    localparam int DRAIN_N = QL + QN - 1;

    logic clk = 1'b0;
    logic i_rst = 1'b1, i_start = 1'b0;
    logic [AW-1:0] i_base_addr = '0, i_row_stride = '0;
    logic [TW-1:0] i_tile_num = '0;
    logic o_busy, o_done, o_mem_req;
    logic [AW-1:0] o_mem_addr;
    logic i_mem_gnt = 1'b0, i_mem_rvalid = 1'b0;
    logic [ROW_W-1:0] i_mem_rdata = '0;
    logic o_ib_valid;
    logic i_ib_ready = 1'b0;
    logic [QN*ROW_W-1:0] o_ib_data;
    logic i_ib_in_done = 1'b0;
    logic o_ib_ctrl_data_out, o_ib_out_active;
    logic [31:0] o_perf_cycles, o_perf_stall;

    int checks = 0, errors = 0;
    int last_busy = 0, last_done_cyc = -1;

    always #5 clk = ~clk;

    ib_load_scheduler dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_row_stride(i_row_stride), .i_tile_num(i_tile_num), .o_busy(o_busy), .o_done(o_done),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_gnt(i_mem_gnt),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata), .o_ib_valid(o_ib_valid),
        .i_ib_ready(i_ib_ready), .o_ib_data(o_ib_data), .i_ib_in_done(i_ib_in_done),
        .o_ib_ctrl_data_out(o_ib_ctrl_data_out), .o_ib_out_active(o_ib_out_active),
        .o_perf_cycles(o_perf_cycles), .o_perf_stall(o_perf_stall)
    );

    // Runs one job acting as memory and input buffer; abort_mode 1 stops mid-drain of tile 1,
    // abort_mode 2 stops right after a row request of tile 1 is granted (read outstanding).
    task automatic run_job(input string nm, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input int ntiles, input int gnt_dly, input int rv_dly, input int rdy_dly,
                           input int ind_dly, input int abort_mode);
        logic [QN-1:0][ROW_W-1:0] exp_tile;
        logic [ROW_W-1:0] rv_data;
        logic [AW-1:0] exp_addr;
        int req_n, rows_rx, req_wait, rv_wait, push_wait, fires, fire_cyc, ctrl_n, act_n;
        int done_n, busy_n, stall_n, budget, cyc, t, r;
        bit rv_pend, finished, was_pend;
        exp_tile = '0; rv_data = '0;
        req_n = 0; rows_rx = 0; req_wait = 0; rv_wait = 0; push_wait = 0; fires = 0; fire_cyc = 0;
        ctrl_n = 0; act_n = 0; done_n = 0; busy_n = 0; stall_n = 0; rv_pend = 0; finished = 0;
        budget = ntiles * (QN * (gnt_dly + rv_dly + 3) + rdy_dly + ind_dly + DRAIN_N + 6) + 20;
        @(negedge clk);
        i_start = 1'b1; i_base_addr = base; i_row_stride = stride; i_tile_num = TW'(ntiles);
        @(negedge clk);
        for (cyc = 0; cyc < budget && !finished; cyc++) begin
            i_start = cyc == 4 && ntiles > 0;
            i_base_addr = AW'($urandom); i_row_stride = AW'($urandom); i_tile_num = TW'($urandom);
            i_mem_gnt = o_mem_req && req_wait >= gnt_dly;
            i_mem_rvalid = rv_pend && rv_wait >= rv_dly;
            i_mem_rdata = rv_pend ? rv_data : ROW_W'({$urandom, $urandom, $urandom});
            i_ib_ready = o_ib_valid && push_wait >= rdy_dly;
            i_ib_in_done = fires > ctrl_n && (cyc - fire_cyc) >= ind_dly;
            #1;
            was_pend = rv_pend;
            if (i_mem_rvalid) begin
                exp_tile[rows_rx % QN] = rv_data;
                rows_rx++;
                rv_pend = 0;
            end else if (rv_pend) rv_wait++;
            if (o_mem_req) begin
                t = req_n / QN; r = req_n % QN;
                exp_addr = base + AW'(t * QN + r) * stride;
                checks++;
                if (o_mem_addr !== exp_addr || was_pend)
                    $display("FAIL %s mem_addr req %0d: got %h outstanding=%0d, want %h outstanding=0",
                             nm, req_n, o_mem_addr, was_pend, exp_addr);
                if (o_mem_addr !== exp_addr || was_pend) errors++;
                if (i_mem_gnt) begin
                    req_n++; req_wait = 0; rv_pend = 1; rv_wait = 0;
                    rv_data = ROW_W'({$urandom, $urandom, $urandom});
                end else begin
                    req_wait++; stall_n++;
                end
            end
            if (o_ib_valid) begin
                checks++;
                if (o_ib_data !== exp_tile) begin
                    errors++;
                    $display("FAIL %s ib_data tile %0d: got %h want %h", nm, fires, o_ib_data, exp_tile);
                end
                if (i_ib_ready) begin fires++; fire_cyc = cyc; push_wait = 0; end
                else push_wait++;
            end
            if (o_ib_ctrl_data_out) begin
                checks++;
                if (act_n !== ctrl_n * DRAIN_N) begin
                    errors++;
                    $display("FAIL %s drain_len before arm %0d: got %0d want %0d", nm, ctrl_n, act_n, ctrl_n * DRAIN_N);
                end
                ctrl_n++;
            end
            if (o_ib_out_active) act_n++;
            if (done_n > 0) begin
                checks++;
                if (o_busy !== 1'b0 || o_done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s idle_after_done: busy=%b done=%b want 0 0", nm, o_busy, o_done);
                end
                finished = 1;
            end else begin
                if (o_busy) busy_n++;
                if (o_done) begin done_n++; last_done_cyc = cyc; end
            end
            if (abort_mode == 1 && act_n == DRAIN_N + 3) finished = 1;
            if (abort_mode == 2 && req_n == QN + 1 && rv_pend) finished = 1;
            if (!finished) @(negedge clk);
        end
        i_start = 1'b0;
        last_busy = busy_n;
        if (abort_mode == 0) begin
            checks++;
            if (!finished) begin
                errors++;
                $display("FAIL %s timeout: no done within %0d cycles", nm, budget);
            end
            checks++;
            if (req_n != ntiles * QN || fires != ntiles || ctrl_n != ntiles || act_n != ntiles * DRAIN_N || done_n != 1) begin
                errors++;
                $display("FAIL %s counts: reqs=%0d fires=%0d arms=%0d active=%0d dones=%0d want %0d %0d %0d %0d 1",
                         nm, req_n, fires, ctrl_n, act_n, done_n, ntiles * QN, ntiles, ntiles, ntiles * DRAIN_N);
            end
            checks++;
`ifdef IB_SCHED_PERF_EN
            if (o_perf_cycles !== 32'(busy_n) || o_perf_stall !== 32'(stall_n)) begin
                errors++;
                $display("FAIL %s perf: cycles=%0d stall=%0d want %0d %0d", nm, o_perf_cycles, o_perf_stall, busy_n, stall_n);
            end
`else
            if (o_perf_cycles !== 32'd0 || o_perf_stall !== 32'd0) begin
                errors++;
                $display("FAIL %s perf_tied: cycles=%0d stall=%0d want 0 0", nm, o_perf_cycles, o_perf_stall);
            end
`endif
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({o_busy, o_done, o_mem_req, o_mem_addr, o_ib_valid, o_ib_ctrl_data_out, o_ib_out_active,
             o_perf_cycles, o_perf_stall} !== '0 || o_ib_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b req=%b addr=%h valid=%b data=%h", o_busy, o_done,
                     o_mem_req, o_mem_addr, o_ib_valid, o_ib_data);
        end
        i_rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b req=%b want 0 0", o_busy, o_mem_req);
        end
    endtask

    task automatic test_basic();
        run_job("basic", 16'h0100, 16'h0010, 1, 0, 0, 0, 1, 0);
    endtask

    task automatic test_zero_tiles();
        run_job("zero_tiles", 16'h1234, 16'h0004, 0, 0, 0, 0, 1, 0);
        checks++;
        if (last_busy != 1 || last_done_cyc != 0) begin
            errors++;
            $display("FAIL zero_tiles timing: busy_cycles=%0d done_cycle=%0d want 1 0", last_busy, last_done_cyc);
        end
    endtask

    task automatic test_wrap();
        run_job("wrap", 16'hFFF0, 16'h0008, 2, 0, 0, 0, 1, 0);
    endtask

    task automatic test_gnt_stall();
        run_job("gnt_stall", 16'h0200, 16'h0020, 1, 5, 1, 0, 2, 0);
`ifdef IB_SCHED_PERF_EN
        checks++;
        if (o_perf_stall !== 32'(5 * QN)) begin
            errors++;
            $display("FAIL gnt_stall perf_stall: got %0d want %0d", o_perf_stall, 5 * QN);
        end
`endif
    endtask

    task automatic test_ready_stall();
        run_job("ready_stall", 16'h0300, 16'h0100, 2, 1, 2, 4, 3, 0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 6; j++)
            run_job("random", AW'($urandom), AW'($urandom), $urandom_range(1, 4), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 3), 0);
    endtask

    task automatic test_max_tiles();
        run_job("max_tiles", AW'($urandom), AW'($urandom), 255, 0, 0, 0, 1, 0);
    endtask

    task automatic test_reset_mid_drain();
        run_job("abort_drain", 16'h0400, 16'h0010, 3, 0, 0, 0, 1, 1);
        @(negedge clk);
        i_rst = 1'b1; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_ib_ready = 1'b0; i_ib_in_done = 1'b0;
        @(negedge clk);
        i_rst = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = ROW_W'({$urandom, $urandom, $urandom});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({o_busy, o_done, o_mem_req, o_mem_addr, o_ib_valid, o_ib_ctrl_data_out, o_ib_out_active,
                 o_perf_cycles, o_perf_stall} !== '0 || o_ib_data !== '0) begin
                errors++;
                $display("FAIL abort_drain reset_state: busy=%b req=%b active=%b data=%h", o_busy, o_mem_req,
                         o_ib_out_active, o_ib_data);
            end
        end
        i_mem_rvalid = 1'b0;
        run_job("after_drain_reset", 16'h0500, 16'h0030, 2, 1, 0, 1, 1, 0);
    endtask

    task automatic test_reset_mid_fetch();
        run_job("abort_fetch", 16'h0600, 16'h0040, 3, 0, 1, 0, 1, 2);
        @(negedge clk);
        i_rst = 1'b1; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_ib_ready = 1'b0; i_ib_in_done = 1'b0;
        @(negedge clk);
        i_rst = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = ROW_W'({$urandom, $urandom, $urandom});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({o_busy, o_done, o_mem_req, o_mem_addr, o_ib_valid, o_ib_ctrl_data_out, o_ib_out_active,
                 o_perf_cycles, o_perf_stall} !== '0 || o_ib_data !== '0) begin
                errors++;
                $display("FAIL abort_fetch stray_rvalid: busy=%b req=%b addr=%h data=%h", o_busy, o_mem_req,
                         o_mem_addr, o_ib_data);
            end
        end
        i_mem_rvalid = 1'b0;
        run_job("after_fetch_reset", 16'h0700, 16'h0008, 1, 0, 0, 0, 1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_tiles();
        test_wrap();
        test_gnt_stall();
        test_ready_stall();
        test_random();
        test_max_tiles();
        test_reset_mid_drain();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
